// File: rtl/dual_rail_sync_join_if.sv
// Handshake bundle for the dual-rail to valid/ready join.
// master: environment side; slave: the join itself.
interface dual_rail_sync_join_if #(
  parameter int NCH   = 3,
  parameter int WIDTH = 16
);
  logic [2*NCH*WIDTH-1:0] data_i;
  logic [NCH-1:0]         ack_o;
  logic [NCH-1:0]         ch_en_i;
  logic [NCH*WIDTH-1:0]   out_data_o;
  logic [NCH-1:0]         out_mask_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic                   err_o;
  logic                   err_clr_i;

  modport master (
    output data_i,
    output ch_en_i,
    output out_ready_i,
    output err_clr_i,
    input  ack_o,
    input  out_data_o,
    input  out_mask_o,
    input  out_valid_o,
    input  err_o
  );

  modport slave (
    input  data_i,
    input  ch_en_i,
    input  out_ready_i,
    input  err_clr_i,
    output ack_o,
    output out_data_o,
    output out_mask_o,
    output out_valid_o,
    output err_o
  );
endinterface

// File: rtl/dual_rail_sync_join.sv
// N-channel four-phase dual-rail join into one valid/ready word.
// Each channel is synchronised, completion-detected and held.
module dual_rail_sync_join #(
  parameter int NCH         = 3,
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  dual_rail_sync_join_if.slave bus
);

  localparam int DW = 2*NCH*WIDTH;

  typedef enum logic [1:0] {
    EMPTY,
    HELD,
    RTZ,
    DRAIN
  } ch_state_e;

  logic [DW-1:0]        sync_q [SYNC_STAGES];
  logic [DW-1:0]        rails;
  logic [NCH-1:0]       comp;
  logic [NCH-1:0]       spc;
  logic [NCH-1:0]       bad;
  logic [NCH*WIDTH-1:0] trail;

  ch_state_e            state_q [NCH];
  ch_state_e            state_d [NCH];
  logic [NCH*WIDTH-1:0] hold_q;
  logic [NCH*WIDTH-1:0] hold_d;
  logic [NCH-1:0]       en_q;
  logic [NCH-1:0]       en_d;
  logic                 err_q;
  logic                 err_d;

  logic                 all_empty;
  logic                 full;
  logic                 valid;
  logic                 fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.data_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign rails = sync_q[SYNC_STAGES-1];

  // rails are {t,f}; t alone is the single-rail value
  always_comb begin
    comp  = '1;
    spc   = '1;
    bad   = '0;
    trail = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int b = 0; b < WIDTH; b++) begin
        comp[c] &= rails[2*(c*WIDTH+b)+1]
                 ^ rails[2*(c*WIDTH+b)];
        spc[c]  &= ~(rails[2*(c*WIDTH+b)+1]
                 | rails[2*(c*WIDTH+b)]);
        bad[c]  |= rails[2*(c*WIDTH+b)+1]
                 & rails[2*(c*WIDTH+b)];
        trail[c*WIDTH+b] = rails[2*(c*WIDTH+b)+1];
      end
    end
  end

  always_comb begin
    all_empty = 1'b1;
    full      = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (state_q[c] != EMPTY)
        all_empty = 1'b0;
      if (en_q[c] && !(state_q[c] == HELD ||
                       state_q[c] == RTZ))
        full = 1'b0;
    end
    valid = (en_q != '0) && full;
    fire  = valid && bus.out_ready_i;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    en_d    = all_empty ? bus.ch_en_i : en_q;
    err_d   = (|(bad & en_q)) |
              (err_q & ~bus.err_clr_i);
    for (int c = 0; c < NCH; c++) begin
      if (!en_q[c]) begin
        state_d[c] = EMPTY;
      end else begin
        unique case (state_q[c])
          EMPTY: if (comp[c]) begin
            state_d[c] = HELD;
            hold_d[c*WIDTH +: WIDTH] =
              trail[c*WIDTH +: WIDTH];
          end
          HELD: begin
            if (fire && spc[c])
              state_d[c] = EMPTY;
            else if (fire)
              state_d[c] = DRAIN;
            else if (spc[c])
              state_d[c] = RTZ;
          end
          RTZ:   if (fire)   state_d[c] = EMPTY;
          DRAIN: if (spc[c]) state_d[c] = EMPTY;
          default: state_d[c] = EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NCH; c++)
        state_q[c] <= EMPTY;
      hold_q <= '0;
      en_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++)
        state_q[c] <= state_d[c];
      hold_q <= hold_d;
      en_q   <= en_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    bus.ack_o      = '0;
    bus.out_data_o = '0;
    for (int c = 0; c < NCH; c++) begin
      bus.ack_o[c] = (state_q[c] == HELD) ||
                     (state_q[c] == DRAIN);
      if (en_q[c])
        bus.out_data_o[c*WIDTH +: WIDTH] =
          hold_q[c*WIDTH +: WIDTH];
    end
  end

  assign bus.out_mask_o  = en_q;
  assign bus.out_valid_o = valid;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_dual_rail_sync_join.sv
// Directed bench for dual_rail_sync_join, NCH=3 WIDTH=16.
// Inputs change and outputs are sampled 1 ns after rising edges.
module tb_dual_rail_sync_join;

  localparam int NCH = 3;
  localparam int W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2*NCH*W-1:0] din = '0;
  int checks = 0;
  int errors = 0;

  dual_rail_sync_join_if #(.NCH(NCH), .WIDTH(W)) bus ();

  dual_rail_sync_join #(
    .NCH(NCH), .WIDTH(W), .SYNC_STAGES(2)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ch(input int c, input logic [15:0] v);
    for (int b = 0; b < W; b++)
      din[2*(c*W+b) +: 2] = v[b] ? 2'b10 : 2'b01;
    bus.data_i = din;
  endtask

  task automatic spc_ch(input int c);
    for (int b = 0; b < W; b++)
      din[2*(c*W+b) +: 2] = 2'b00;
    bus.data_i = din;
  endtask

  task automatic spc_all();
    for (int c = 0; c < NCH; c++)
      spc_ch(c);
  endtask

  initial begin
    bus.data_i      = '0;
    bus.ch_en_i     = 3'b111;
    bus.out_ready_i = 1'b0;
    bus.err_clr_i   = 1'b0;
    #3;
    chk("rst_ack",   bus.ack_o, 0);
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_data",  bus.out_data_o, 0);
    chk("rst_mask",  bus.out_mask_o, 0);
    chk("rst_err",   bus.err_o, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // simultaneous arrival, consumer ready
    bus.out_ready_i = 1'b1;
    set_ch(0, 16'h1234);
    set_ch(1, 16'hABCD);
    set_ch(2, 16'h00FF);
    tick(2);
    chk("t1_ack_early", bus.ack_o, 3'b000);
    chk("t1_vld_early", bus.out_valid_o, 0);
    tick(1);
    chk("t1_ack",  bus.ack_o, 3'b111);
    chk("t1_vld",  bus.out_valid_o, 1);
    chk("t1_data", bus.out_data_o, 48'h00FF_ABCD_1234);
    chk("t1_mask", bus.out_mask_o, 3'b111);
    tick(1);
    chk("t1_vld_drop", bus.out_valid_o, 0);
    chk("t1_drain_ack", bus.ack_o, 3'b111);
    spc_all();
    tick(2);
    chk("t1_ack_hold", bus.ack_o, 3'b111);
    tick(1);
    chk("t1_ack_fall", bus.ack_o, 3'b000);

    // staggered arrivals, consumer stalled
    bus.out_ready_i = 1'b0;
    set_ch(0, 16'h1111);
    tick(3);
    chk("t2_ack0", bus.ack_o, 3'b001);
    chk("t2_vld0", bus.out_valid_o, 0);
    tick(7);
    set_ch(1, 16'h2222);
    tick(3);
    chk("t2_ack1", bus.ack_o, 3'b011);
    chk("t2_vld1", bus.out_valid_o, 0);
    tick(7);
    set_ch(2, 16'h3333);
    tick(2);
    chk("t2_vld2_early", bus.out_valid_o, 0);
    tick(1);
    chk("t2_ack2", bus.ack_o, 3'b111);
    chk("t2_vld2", bus.out_valid_o, 1);
    spc_all();
    tick(3);
    chk("t2_rtz_ack",  bus.ack_o, 3'b000);
    chk("t2_rtz_vld",  bus.out_valid_o, 1);
    chk("t2_rtz_data", bus.out_data_o, 48'h3333_2222_1111);
    bus.out_ready_i = 1'b1;
    tick(1);
    bus.out_ready_i = 1'b0;
    chk("t2_fire_vld", bus.out_valid_o, 0);
    chk("t2_fire_ack", bus.ack_o, 3'b000);

    // fire before spacer -> DRAIN, no recapture
    set_ch(0, 16'hAAAA);
    set_ch(1, 16'hBBBB);
    set_ch(2, 16'hCCCC);
    tick(3);
    chk("t3_vld", bus.out_valid_o, 1);
    bus.out_ready_i = 1'b1;
    tick(1);
    bus.out_ready_i = 1'b0;
    chk("t3_drain_vld", bus.out_valid_o, 0);
    chk("t3_drain_ack", bus.ack_o, 3'b111);
    set_ch(0, 16'h5555);
    tick(6);
    chk("t3_no_recap_ack", bus.ack_o, 3'b111);
    chk("t3_no_recap_vld", bus.out_valid_o, 0);
    spc_all();
    tick(3);
    chk("t3_empty_ack", bus.ack_o, 3'b000);
    set_ch(0, 16'h0F0F);
    set_ch(1, 16'hF0F0);
    set_ch(2, 16'h1357);
    tick(3);
    chk("t3_new_vld",  bus.out_valid_o, 1);
    chk("t3_new_data", bus.out_data_o, 48'h1357_F0F0_0F0F);
    bus.out_ready_i = 1'b1;
    tick(1);
    bus.out_ready_i = 1'b0;
    spc_all();
    tick(3);
    chk("t3_idle_ack", bus.ack_o, 3'b000);

    // partial mask with garbage on disabled channels
    bus.ch_en_i = 3'b010;
    tick(2);
    set_ch(0, 16'h1234);
    set_ch(1, 16'hBEEF);
    din[2*2*W +: 2*W] = '1;
    bus.data_i = din;
    tick(3);
    chk("t4_ack",  bus.ack_o, 3'b010);
    chk("t4_vld",  bus.out_valid_o, 1);
    chk("t4_data", bus.out_data_o, 48'h0000_BEEF_0000);
    chk("t4_mask", bus.out_mask_o, 3'b010);
    chk("t4_err",  bus.err_o, 0);
    bus.out_ready_i = 1'b1;
    tick(1);
    bus.out_ready_i = 1'b0;
    spc_all();
    tick(3);
    chk("t4_idle_ack", bus.ack_o, 3'b000);
    bus.ch_en_i = 3'b111;
    tick(2);
    chk("t4_mask_back", bus.out_mask_o, 3'b111);

    // illegal 11 pair on channel 2 bit 5
    set_ch(0, 16'h0001);
    set_ch(1, 16'h0002);
    set_ch(2, 16'h0004);
    din[2*(2*W+5) +: 2] = 2'b11;
    bus.data_i = din;
    tick(2);
    chk("t5_err_early", bus.err_o, 0);
    tick(1);
    chk("t5_err", bus.err_o, 1);
    chk("t5_ack", bus.ack_o, 3'b011);
    chk("t5_vld", bus.out_valid_o, 0);
    bus.err_clr_i = 1'b1;
    tick(1);
    bus.err_clr_i = 1'b0;
    chk("t5_set_wins", bus.err_o, 1);
    spc_ch(2);
    tick(3);
    chk("t5_err_sticky", bus.err_o, 1);
    bus.err_clr_i = 1'b1;
    tick(1);
    bus.err_clr_i = 1'b0;
    chk("t5_err_clr", bus.err_o, 0);
    set_ch(2, 16'h0004);
    tick(3);
    chk("t5_vld_ok",  bus.out_valid_o, 1);
    chk("t5_data_ok", bus.out_data_o, 48'h0004_0002_0001);
    bus.out_ready_i = 1'b1;
    tick(1);
    bus.out_ready_i = 1'b0;
    spc_all();
    tick(3);

    // async reset mid-handshake
    bus.ch_en_i = 3'b101;
    tick(2);
    set_ch(0, 16'h00AA);
    set_ch(2, 16'h00BB);
    tick(3);
    chk("t6_ack_pre", bus.ack_o, 3'b101);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ack", bus.ack_o, 3'b000);
    chk("t6_rst_vld", bus.out_valid_o, 0);
    chk("t6_rst_err", bus.err_o, 0);
    spc_all();
    bus.ch_en_i = 3'b111;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    set_ch(0, 16'hCAFE);
    set_ch(1, 16'h0BAD);
    set_ch(2, 16'hF00D);
    tick(3);
    chk("t6_ack",  bus.ack_o, 3'b111);
    chk("t6_vld",  bus.out_valid_o, 1);
    chk("t6_data", bus.out_data_o, 48'hF00D_0BAD_CAFE);
    bus.out_ready_i = 1'b1;
    tick(1);
    chk("t6_fire", bus.out_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dual_rail_sync_join.md
Name: dual_rail_sync_join

Overview:
- Parametrised, clocked N-channel join that bridges the asynchronous dual-rail datapath into the synchronous domain.
- Each input channel is a four-phase, return-to-zero dual-rail bundle with its own acknowledge.
- Each channel is synchronised, completion-detected and captured into a per-channel holding register.
- When every enabled channel holds data, the block presents one merged single-rail word on a valid/ready port, and releases each channel's handshake independently.

Parameters:
- NCH, 3, number of input channels (1..8).
- WIDTH, 16, data bits per channel.
- SYNC_STAGES, 2, synchroniser flops per rail (2..3).

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- data_i  in  NCH*WIDTH*2  dual-rail inputs. Channel c, bit b occupies [2*(c*WIDTH+b)+1 : 2*(c*WIDTH+b)]. Rail encoding {t,f}: 00 spacer, 01 = 0, 10 = 1, 11 illegal.
- ack_o  out  NCH  per-channel four-phase acknowledge.
- ch_en_i  in  NCH  channel-enable mask.
- out_data_o  out  NCH*WIDTH  merged single-rail data; channel c in [c*WIDTH +: WIDTH].
- out_mask_o  out  NCH  enable mask that belongs to the presented word.
- out_valid_o  out  1  merged word valid.
- out_ready_i  in  1  consumer ready.
- err_o  out  1  sticky: illegal 11 encoding seen on an enabled channel.
- err_clr_i  in  1  clears err_o.

Behaviour:
- Reset (async assert, sync deassert internally not required): all synchroniser flops 0, ack_o=0, out_valid_o=0, out_data_o=0, out_mask_o=0, err_o=0, all channels EMPTY, en_q=0.
- Synchronisation: every rail passes through SYNC_STAGES flops. Completion and spacer are evaluated on synchronised rails only.
  - comp[c] = every bit of channel c is 01 or 10.
  - spc[c] = every bit of channel c is 00.
  - Dual-rail monotonicity makes skew between bits harmless; no extra filtering.
- Mask latch: en_q <= ch_en_i on any edge where every channel is EMPTY.
  - ch_en_i changes at other times are ignored until the next all-EMPTY edge.
  - out_mask_o = en_q.
- Per-channel FSM (channels with en_q[c]=0 stay EMPTY, ack_o[c]=0, data ignored, out bits 0):
  - EMPTY: comp[c] -> capture the t-rails into buf[c], go HELD. ack_o[c]=0.
  - HELD: ack_o[c]=1.
    - fire && spc[c] -> EMPTY.
    - fire -> DRAIN.
    - spc[c] -> RTZ.
  - RTZ: ack_o[c]=0, data retained. fire -> EMPTY.
  - DRAIN: ack_o[c]=1, buffer free. spc[c] -> EMPTY.
  - A channel cannot recapture until it is back in EMPTY. This gives one word of buffering per channel.
- Output:
  - out_valid_o = (en_q != 0) && every enabled channel is in HELD or RTZ.
  - fire = out_valid_o && out_ready_i.
  - out_data_o = buf contents, registered, stable while out_valid_o=1.
  - Valid/ready rules: out_valid_o never drops without fire; no combinational path from out_ready_i to out_valid_o.
- Latency: the last rail of the last enabled channel going valid at the pins reaches ack_o[c]=1 and out_valid_o=1 after SYNC_STAGES+1 rising edges. Spacer to ack_o falling also takes SYNC_STAGES+1 edges.
- Illegal encoding:
  - Any synchronised 11 pair on an enabled channel sets err_o on the next edge.
  - That channel is not complete while any pair is 11.
  - err_clr_i clears err_o; a set in the same cycle wins.
- en_q = 0: out_valid_o stays 0 and no ack is issued.
- Reset mid-handshake: ack_o drops immediately (async). The sender sees a premature ack fall; system reset covers both sides.

Test Plan:
- NCH=3, WIDTH=16, all enabled; drive 0x1234, 0xABCD, 0x00FF valid on the same cycle, out_ready_i=1.
  -> ack_o=3'b111 and out_valid_o=1 after 3 edges; out_data_o=0x00FF_ABCD_1234 for one cycle; spacers drop each ack 3 edges later.
- Stagger channel arrivals by 10 cycles each, out_ready_i=0.
  -> ack_o rises per channel as each arrives; out_valid_o only after channel 2.
  -> Channels return spacer: acks fall, out_valid_o stays 1, data stable. Assert out_ready_i: all channels go EMPTY.
- Channel 0 held in HELD, fire asserted while the spacer is still absent.
  -> state DRAIN, ack_o[0] stays 1. New valid data on channel 0 is not captured until its spacer is seen.
- ch_en_i=3'b010, channel 1 = 0xBEEF, channels 0/2 driven with garbage.
  -> ack_o=3'b010, out_data_o=0x0000_BEEF_0000, out_mask_o=3'b010.
- Bit 5 of channel 2 driven 11.
  -> err_o=1 three edges later, no ack on channel 2, out_valid_o=0. err_clr_i pulse clears err_o only after the pair is removed.
- rst_ni low mid-transfer with ack_o=3'b101.
  -> ack_o=0, out_valid_o=0, err_o=0 asynchronously. After release, the next clean transaction completes normally.
